// File: rtl/uart_rx_fifo_if.sv
// Bundle between the UART receiver / processor side and the RX FIFO.
// Master drives bytes and pops; slave is the FIFO.
interface uart_rx_fifo_if #(
   parameter int ADDR_W = 4
) ();
   logic [7:0]      data_in;
   logic            parity_status;
   logic            data_ready;
   logic            ack_rx;
   logic            rd_en;
   logic [7:0]      rd_data;
   logic            rd_parity_err;
   logic            empty;
   logic            full;
   logic [ADDR_W:0] count;
   logic            overrun;
   logic            clear_overrun;

   modport master (
      output data_in, parity_status, data_ready,
      output rd_en, clear_overrun,
      input  ack_rx, rd_data, rd_parity_err,
      input  empty, full, count, overrun
   );

   modport slave (
      input  data_in, parity_status, data_ready,
      input  rd_en, clear_overrun,
      output ack_rx, rd_data, rd_parity_err,
      output empty, full, count, overrun
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind a UART receiver: edge-captures data_ready,
// acks the receiver, buffers {parity, byte} with first-word-fall-through.
module uart_rx_fifo #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input logic          clk,
   input logic          reset,
   uart_rx_fifo_if.slave bus
);
   localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);

   logic [8:0]        mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   cnt;
   logic              data_ready_q;
   logic              ack_q;
   logic              ovr_q;

   logic       capture;
   logic       is_empty;
   logic       is_full;
   logic       pop;
   logic       wr_ok;
   logic       drop;
   logic [8:0] head;

   always_comb begin
      is_empty = (cnt == '0);
      is_full  = (cnt == CNT_FULL);
      capture  = bus.data_ready & ~data_ready_q;
      pop      = bus.rd_en & ~is_empty;
      // a pop on the same edge frees the slot a full FIFO needs
      wr_ok    = capture & (~is_full | pop);
      drop     = capture & is_full & ~pop;
      head     = mem[rd_ptr];
   end

   always_ff @(posedge clk) begin
      if (wr_ok && !reset) begin
         mem[wr_ptr] <= {bus.parity_status, bus.data_in};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         cnt          <= '0;
         data_ready_q <= 1'b0;
         ack_q        <= 1'b0;
         ovr_q        <= 1'b0;
      end else begin
         data_ready_q <= bus.data_ready;
         ack_q        <= capture;
         if (wr_ok) begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + ADDR_W'(1);
         end
         case ({wr_ok, pop})
            2'b10:   cnt <= cnt + (ADDR_W+1)'(1);
            2'b01:   cnt <= cnt - (ADDR_W+1)'(1);
            default: cnt <= cnt;
         endcase
         if (drop) begin
            ovr_q <= 1'b1;
         end else if (bus.clear_overrun) begin
            ovr_q <= 1'b0;
         end
      end
   end

   assign bus.ack_rx        = ack_q;
   assign bus.rd_data       = is_empty ? 8'h00 : head[7:0];
   assign bus.rd_parity_err = ~is_empty & ~head[8];
   assign bus.empty         = is_empty;
   assign bus.full          = is_full;
   assign bus.count         = cnt;
   assign bus.overrun       = ovr_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo; a scoreboard queue holds the
// expected {parity_err, byte} and a negedge monitor checks every pop.
module tb_uart_rx_fifo;
   logic clk = 1'b0;
   logic reset;

   uart_rx_fifo_if #(.ADDR_W(4)) bus ();

   uart_rx_fifo #(
      .DEPTH (16),
      .ADDR_W(4)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int         vectors     = 0;
   int         miscompares = 0;
   int         ack_cnt     = 0;
   int         max_cnt     = 0;
   int         ackb;
   logic [8:0] exp_q[$];
   logic [8:0] mon_e;
   logic [7:0] last_pop;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: scoreboard pops and empty-output checks.
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.ack_rx === 1'b1) ack_cnt++;
         if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
         if (bus.empty === 1'b1) begin
            chk("empty_rd_data", bus.rd_data, 0);
            chk("empty_parity_err", bus.rd_parity_err, 0);
         end
         if (bus.rd_en && bus.empty === 1'b0) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL pop_unexpected: got 0x%0h, want none",
                        bus.rd_data);
            end else begin
               mon_e = exp_q.pop_front();
               chk("pop_data", {bus.rd_parity_err, bus.rd_data}, mon_e);
               last_pop = bus.rd_data;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b, input logic par,
                       input logic pop_too);
      bus.data_in       = b;
      bus.parity_status = par;
      bus.data_ready    = 1'b1;
      bus.rd_en         = pop_too;
      if (exp_q.size() < 16 || pop_too) exp_q.push_back({~par, b});
      tick();
      chk("ack_pulse", bus.ack_rx, 1);
      bus.rd_en      = 1'b0;
      bus.data_ready = 1'b0;
      tick();
      chk("ack_low", bus.ack_rx, 0);
   endtask

   task automatic pop();
      bus.rd_en = 1'b1;
      tick();
      bus.rd_en = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1);
   end

   initial begin
      reset             = 1'b1;
      bus.data_in       = 8'h00;
      bus.parity_status = 1'b1;
      bus.data_ready    = 1'b0;
      bus.rd_en         = 1'b0;
      bus.clear_overrun = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      chk("rst_count", bus.count, 0);
      chk("rst_empty", bus.empty, 1);
      chk("rst_full", bus.full, 0);
      chk("rst_rd_data", bus.rd_data, 0);
      chk("rst_parity_err", bus.rd_parity_err, 0);
      chk("rst_overrun", bus.overrun, 0);
      chk("rst_ack", bus.ack_rx, 0);

      pop();
      chk("pop_empty_count", bus.count, 0);
      chk("pop_empty_empty", bus.empty, 1);

      send(8'h41, 1'b1, 1'b0);
      chk("single_count", bus.count, 1);
      chk("single_empty", bus.empty, 0);
      chk("single_rd_data", bus.rd_data, 8'h41);
      chk("single_parity_err", bus.rd_parity_err, 0);
      pop();
      chk("single_pop_empty", bus.empty, 1);
      chk("single_pop_rd_data", bus.rd_data, 0);

      send(8'h3C, 1'b1, 1'b1);
      chk("cap_pop_empty_count", bus.count, 1);
      pop();

      ackb = ack_cnt;
      for (int i = 0; i < 16; i++) send(8'(i), 1'b1, 1'b0);
      chk("fill_full", bus.full, 1);
      chk("fill_count", bus.count, 16);
      chk("fill_overrun", bus.overrun, 0);
      send(8'h10, 1'b1, 1'b0);
      chk("ovf_overrun", bus.overrun, 1);
      chk("ovf_count", bus.count, 16);
      chk("ovf_acks", ack_cnt - ackb, 17);
      for (int i = 0; i < 16; i++) pop();
      chk("drain_empty", bus.empty, 1);
      chk("drain_last", last_pop, 8'h0F);
      bus.clear_overrun = 1'b1;
      tick();
      bus.clear_overrun = 1'b0;
      chk("clear_overrun", bus.overrun, 0);

      for (int i = 0; i < 16; i++) send(8'(8'h80 + i), 1'b1, 1'b0);
      send(8'hAA, 1'b1, 1'b1);
      chk("full_cap_pop_count", bus.count, 16);
      chk("full_cap_pop_overrun", bus.overrun, 0);
      for (int i = 0; i < 16; i++) pop();
      chk("full_cap_pop_last", last_pop, 8'hAA);
      chk("full_cap_pop_empty", bus.empty, 1);

      max_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         send(8'(i * 7 + 3), 1'(i % 2), 1'b0);
         pop();
      end
      chk("wrap_max_le_1", max_cnt <= 1, 1);
      chk("wrap_overrun", bus.overrun, 0);
      chk("wrap_empty", bus.empty, 1);

      send(8'h55, 1'b0, 1'b0);
      chk("parity_err", bus.rd_parity_err, 1);
      chk("parity_rd_data", bus.rd_data, 8'h55);
      pop();
      for (int i = 0; i < 16; i++) send(8'(8'hC0 + i), 1'b1, 1'b0);
      bus.clear_overrun = 1'b1;
      bus.data_in       = 8'hEE;
      bus.data_ready    = 1'b1;
      tick();
      bus.clear_overrun = 1'b0;
      bus.data_ready    = 1'b0;
      chk("set_wins_overrun", bus.overrun, 1);
      tick();
      chk("overrun_sticky", bus.overrun, 1);
      bus.clear_overrun = 1'b1;
      tick();
      bus.clear_overrun = 1'b0;
      chk("clear_alone", bus.overrun, 0);
      for (int i = 0; i < 16; i++) pop();
      chk("parity_drain_empty", bus.empty, 1);

      for (int i = 0; i < 5; i++) send(8'(8'h10 + i), 1'b1, 1'b0);
      chk("pre_reset_count", bus.count, 5);
      reset             = 1'b1;
      bus.data_in       = 8'h77;
      bus.parity_status = 1'b1;
      bus.data_ready    = 1'b1;
      tick();
      chk("mid_rst_count", bus.count, 0);
      chk("mid_rst_empty", bus.empty, 1);
      chk("mid_rst_rd_data", bus.rd_data, 0);
      chk("mid_rst_overrun", bus.overrun, 0);
      chk("mid_rst_ack", bus.ack_rx, 0);
      exp_q.delete();
      reset = 1'b0;
      ackb  = ack_cnt;
      exp_q.push_back({1'b0, 8'h77});
      tick();
      chk("rel_ack", bus.ack_rx, 1);
      chk("rel_count", bus.count, 1);
      tick();
      tick();
      chk("held_ack", bus.ack_rx, 0);
      chk("held_count", bus.count, 1);
      bus.data_ready = 1'b0;
      tick();
      chk("held_acks", ack_cnt - ackb, 1);
      pop();
      chk("final_empty", bus.empty, 1);
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter: DEPTH, 16, number of entries (power of two, 2..64).
REQ-002 Parameter: ADDR_W, 4, log2(DEPTH).
REQ-003 Port: clk  input  1  sole clock; all logic on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: data_in  input  8  received byte from UART receiver, MSBs already zero-filled.
REQ-006 Port: parity_status  input  1  receiver parity check, 1 ok, 0 error.
REQ-007 Port: data_ready  input  1  receiver byte-available flag, level, held until acknowledged.
REQ-008 Port: ack_rx  output  1  one-cycle pulse to the receiver's data_read_nios input, clearing data_ready.
REQ-009 Port: rd_en  input  1  processor pop request.
REQ-010 Port: rd_data  output  8  head-entry byte, first-word-fall-through.
REQ-011 Port: rd_parity_err  output  1  head-entry parity error, i.e. inverted stored parity_status.
REQ-012 Port: empty  output  1  FIFO holds zero entries.
REQ-013 Port: full  output  1  FIFO holds DEPTH entries.
REQ-014 Port: count  output  ADDR_W+1  number of stored entries, 0..DEPTH.
REQ-015 Port: overrun  output  1  sticky flag: a byte was dropped because the FIFO was full.
REQ-016 Port: clear_overrun  input  1  synchronous clear of overrun.

Function
REQ-017 Capture event: data_ready sampled 1 at a clock edge while the internal registered copy data_ready_q is 0; data_ready_q updates every edge.
REQ-018 Capture event, not full: write {parity_status, data_in} at wr_ptr on the same edge, then increment wr_ptr modulo DEPTH.
REQ-019 Capture event, full (without simultaneous pop): discard the byte, set overrun; FIFO contents, pointers and count are unchanged.
REQ-020 Every capture event, accepted or dropped: ack_rx is 1 for exactly the one cycle after the capturing edge, otherwise 0.
REQ-021 Latency, capture edge to visibility: count and empty reflect the write immediately after the capturing edge; rd_data is valid in that same cycle when the FIFO was previously empty.
REQ-022 Pop: rd_en=1 with empty=0 advances rd_ptr modulo DEPTH; the next entry appears on rd_data after that edge.
REQ-023 Pop while empty: ignored; no pointer or count change and no error flag.
REQ-024 Simultaneous capture and pop, neither empty nor full: both occur and count is unchanged.
REQ-025 Simultaneous capture and pop while full: the pop frees the slot, the write is accepted, count stays DEPTH, and overrun is not set.
REQ-026 Simultaneous capture and pop while empty: pop ignored, write accepted, count becomes 1.
REQ-027 count: incremented by an accepted write without a pop, decremented by a pop without a write; never exceeds DEPTH and never goes below 0.
REQ-028 Flags: empty = (count==0), full = (count==DEPTH), both derived from registered state.
REQ-029 rd_data and rd_parity_err are 0 while empty; otherwise they show the head entry.
REQ-030 Pointers: wr_ptr and rd_ptr are ADDR_W bits wide and wrap from DEPTH-1 to 0 with no gap.
REQ-031 overrun set wins over clear_overrun in the same cycle; otherwise clear_overrun drives overrun to 0 on the next edge.
REQ-032 A data_ready level held high across multiple cycles produces only one capture event.

Reset
REQ-033 While reset=1 at an edge: wr_ptr=0, rd_ptr=0, count=0, data_ready_q=0, overrun=0, ack_rx=0.
REQ-034 Outputs after reset: empty=1, full=0, rd_data=0, rd_parity_err=0; memory contents need not be cleared.
REQ-035 Reset asserted mid-operation discards all stored entries; any ack_rx pulse in flight is suppressed.
REQ-036 If data_ready is already 1 on the first edge after reset release, that edge is a capture event.

Verification
REQ-037 Single byte: data_ready rises with data_in=0x41, parity_status=1 -> ack_rx pulses one cycle; count=1, empty=0, rd_data=0x41, rd_parity_err=0; then rd_en one cycle -> empty=1, rd_data=0.
REQ-038 Fill plus overrun: 17 capture events with bytes 0x00..0x10 and no pops -> full=1 after the 16th, overrun=1 after the 17th, 17 ack_rx pulses; popping gives 0x00..0x0F in order.
REQ-039 Full with simultaneous capture and pop: FIFO full, byte 0xAA captured on the same edge as rd_en -> count stays 16, overrun stays 0, and 0xAA is the last byte read.
REQ-040 Pointer wrap: 40 bytes streamed with one pop per capture -> read order matches write order, count never exceeds 1, no overrun.
REQ-041 Parity and overrun clear: byte 0x55 captured with parity_status=0 -> rd_parity_err=1; overflow and clear_overrun on the same edge -> overrun=1; clear_overrun alone on a later edge -> overrun=0.
REQ-042 Reset mid-stream: 5 entries stored, then reset pulsed one cycle -> count=0, empty=1, rd_data=0, overrun=0; data_ready held high through reset release -> exactly one capture.
